// File: rtl/mem_ctrl.sv
// Word-addressed DEPTH x 32 memory controller with programmable wait states and a side preload port.
// Define MEM_CTRL_BOUNDS_EN to flag out-of-range addresses on err instead of wrapping modulo DEPTH.
`timescale 1ns/1ps
module mem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_rw,
    input  logic [31:0]   cpu_address,
    input  logic [31:0]   cpu_datao,
    output logic [31:0]   cpu_data,
    output logic          cpu_ready,
    output logic          busy,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
`ifdef MEM_CTRL_BOUNDS_EN
    ,
    output logic          err
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          lat_rw;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_data;
    logic [31:0]   mem [DEPTH];

`ifdef MEM_CTRL_BOUNDS_EN
    logic          lat_oob;
`else
    // Upper address bits deliberately take no part in addressing; accesses wrap.
    logic          addr_unused;
    assign addr_unused = ^cpu_address[31:AW];
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cpu_data  <= 32'd0;
            cpu_ready <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_CTRL_BOUNDS_EN
            err       <= 1'b0;
`endif
        end else begin
            cpu_ready <= 1'b0;
`ifdef MEM_CTRL_BOUNDS_EN
            err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A cpu request takes precedence; a coincident preload is dropped.
                    if (cpu_req) begin
                        lat_rw   <= cpu_rw;
                        lat_idx  <= cpu_address[AW-1:0];
                        lat_data <= cpu_datao;
`ifdef MEM_CTRL_BOUNDS_EN
                        lat_oob  <= |cpu_address[31:AW];
`endif
                        cnt      <= 4'(WAIT_STATES);
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end else if (load_en) begin
                        mem[load_addr] <= load_data;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state     <= DONE;
                        cpu_ready <= 1'b1;
`ifdef MEM_CTRL_BOUNDS_EN
                        if (lat_oob) begin
                            err <= 1'b1;
                            if (lat_rw)
                                cpu_data <= 32'hDEADBEEF;
                        end else
`endif
                        if (lat_rw)
                            cpu_data <= mem[lat_idx];
                        else
                            mem[lat_idx] <= lat_data;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
